// File: rtl/abcd_stim_pkg.sv
// Shared codes for the abcd_stim_seq stimulus stage: mode codes, FSM states and
// the last-vector index per pattern.
package abcd_stim_pkg;

  localparam logic [1:0] MODE_BIN  = 2'b00;
  localparam logic [1:0] MODE_GRAY = 2'b01;
  localparam logic [1:0] MODE_WALK = 2'b10;

  localparam logic [3:0] LAST_BIN  = 4'd15;
  localparam logic [3:0] LAST_WALK = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Gray shares the 16-entry length of binary; code 11 also falls back to binary.
  function automatic logic [3:0] last_idx(input logic [1:0] mode);
    return (mode == MODE_WALK) ? LAST_WALK : LAST_BIN;
  endfunction

endpackage

// File: rtl/abcd_stim_seq_bin2gray4.sv
// 4-bit binary to reflected-gray converter used by the abcd_stim_seq vector mux.
module bin2gray4 (
  input  logic [3:0] bin,
  output logic [3:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/abcd_stim_seq.sv
// Pattern sequencer driving the comb_logic inputs A..D, with a programmable hold per vector.
// Define ABCD_STIM_RESP_CHECK_EN to add the Y1/Y2 response counters.
module abcd_stim_seq
  import abcd_stim_pkg::*;
#(
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              loop_en,
`ifdef ABCD_STIM_RESP_CHECK_EN
  input  logic              Y1,
  input  logic              Y2,
  output logic [4:0]        y1_cnt,
  output logic [4:0]        y2_cnt,
`endif
  output logic              A,
  output logic              B,
  output logic              C,
  output logic              D,
  output logic              vec_valid,
  output logic [3:0]        vec_idx,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  // Control interface: start is a level sampled only in IDLE (no ready back);
  // stop wins over start and aborts RUN on the next edge without a done pulse.

  state_e            state, state_n;
  logic [3:0]        idx, idx_n;
  logic [HOLD_W-1:0] cnt, cnt_n;
  logic [1:0]        lat_mode, lat_mode_n;
  logic [HOLD_W-1:0] lat_hold, lat_hold_n;
  logic              lat_loop, lat_loop_n;
  logic              valid_n, busy_n, done_n;
  logic [3:0]        vec, vec_n;
  logic [3:0]        gray_n;
  logic              hold_exp;
  logic              run_begin;

  bin2gray4 u_bin2gray4 (
    .bin  (idx_n),
    .gray (gray_n)
  );

  assign hold_exp  = (state == ST_RUN) && !stop && (cnt >= lat_hold);
  assign run_begin = (state == ST_IDLE) && start && !stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cnt       <= '0;
      lat_mode  <= '0;
      lat_hold  <= '0;
      lat_loop  <= 1'b0;
      vec       <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      lat_mode  <= lat_mode_n;
      lat_hold  <= lat_hold_n;
      lat_loop  <= lat_loop_n;
      vec       <= vec_n;
      vec_valid <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cnt_n      = cnt;
    lat_mode_n = lat_mode;
    lat_hold_n = lat_hold;
    lat_loop_n = lat_loop;
    valid_n    = 1'b0;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    vec_n      = '0;

    case (state)
      ST_IDLE: begin
        idx_n = '0;
        cnt_n = '0;
        if (run_begin) begin
          lat_mode_n = mode;
          lat_hold_n = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
          lat_loop_n = loop_en;
          state_n    = ST_RUN;
          cnt_n      = HOLD_W'(1);
          valid_n    = 1'b1;
          busy_n     = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_n = ST_IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end else if (hold_exp) begin
          cnt_n = HOLD_W'(1);
          if (idx != last_idx(lat_mode)) begin
            idx_n   = idx + 4'd1;
            valid_n = 1'b1;
            busy_n  = 1'b1;
          end else if (lat_loop) begin
            idx_n   = '0;
            valid_n = 1'b1;
            busy_n  = 1'b1;
          end else begin
            state_n = ST_DONE;
            idx_n   = '0;
            cnt_n   = '0;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n   = cnt + HOLD_W'(1);
          valid_n = 1'b1;
          busy_n  = 1'b1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        idx_n   = '0;
        cnt_n   = '0;
      end
      default: begin
        state_n = ST_IDLE;
        idx_n   = '0;
        cnt_n   = '0;
      end
    endcase

    // Vector is derived from the next index so it lands in the same cycle as vec_idx.
    if (valid_n) begin
      case (lat_mode_n)
        MODE_GRAY: vec_n = gray_n;
        MODE_WALK: vec_n = 4'b1000 >> idx_n[1:0];
        default:   vec_n = idx_n;
      endcase
    end
  end

`ifdef ABCD_STIM_RESP_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst || run_begin) begin
      y1_cnt <= '0;
      y2_cnt <= '0;
    end else if (hold_exp) begin
      if (Y1 && (y1_cnt != 5'd31)) y1_cnt <= y1_cnt + 5'd1;
      if (Y2 && (y2_cnt != 5'd31)) y2_cnt <= y2_cnt + 5'd1;
    end
  end
`endif

  assign {A, B, C, D} = vec;
  assign vec_idx      = idx;
  assign state_dbg    = state;

endmodule

// File: tb/tb_abcd_stim_seq.sv
// Directed bench for abcd_stim_seq: expected per-cycle output words are queued when a
// sequence is started and popped/compared one per cycle on the falling edge.
module tb_abcd_stim_seq;

  localparam int HOLD_W = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic              stop;
  logic [1:0]        mode;
  logic [HOLD_W-1:0] hold_cycles;
  logic              loop_en;
  logic              A, B, C, D;
  logic              vec_valid;
  logic [3:0]        vec_idx;
  logic              busy;
  logic              done;
  logic [1:0]        state_dbg;
`ifdef ABCD_STIM_RESP_CHECK_EN
  logic              Y1, Y2;
  logic [4:0]        y1_cnt, y2_cnt;
  assign Y1 = A;
  assign Y2 = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // word = {done, busy, vec_valid, vec_idx[3:0], A, B, C, D}
  logic [10:0] exp_q[$];

  abcd_stim_seq #(.HOLD_W(HOLD_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .hold_cycles (hold_cycles),
    .loop_en     (loop_en),
`ifdef ABCD_STIM_RESP_CHECK_EN
    .Y1          (Y1),
    .Y2          (Y2),
    .y1_cnt      (y1_cnt),
    .y2_cnt      (y2_cnt),
`endif
    .A           (A),
    .B           (B),
    .C           (C),
    .D           (D),
    .vec_valid   (vec_valid),
    .vec_idx     (vec_idx),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] obs_word();
    return {done, busy, vec_valid, vec_idx, A, B, C, D};
  endfunction

  function automatic logic [3:0] model_vec(input logic [1:0] m, input logic [3:0] i);
    logic [3:0] one;
    one = 4'b1000;
    case (m)
      2'b01:   return i ^ {1'b0, i[3:1]};
      2'b10:   return one >> i[1:0];
      default: return i;
    endcase
  endfunction

  // Queue nvec vectors (wrapping at the pattern length), each held h cycles,
  // optionally followed by the DONE word and one IDLE word.
  task automatic push_run(input logic [1:0] m, input int h, input int nvec, input bit with_done);
    int len;
    int hh;
    logic [3:0] i;
    len = (m == 2'b10) ? 4 : 16;
    hh  = (h == 0) ? 1 : h;
    for (int v = 0; v < nvec; v++) begin
      i = 4'(v % len);
      for (int k = 0; k < hh; k++) exp_q.push_back({3'b011, i, model_vec(m, i)});
    end
    if (with_done) begin
      exp_q.push_back(11'b100_0000_0000);
      exp_q.push_back(11'b000_0000_0000);
    end
  endtask

  task automatic check_word(input string tag, input logic [10:0] expv);
    logic [10:0] o;
    o = obs_word();
    total++;
    assert (o === expv) else begin
      bad++;
      $error("FAIL %s observed=%b required=%b", tag, o, expv);
    end
  endtask

  // Compare n queued words, one per falling edge; an empty queue is itself a failure.
  task automatic drain(input string tag, input int n);
    logic [10:0] e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL %s scoreboard empty at cycle %0d observed=%b required=queued word", tag, c, obs_word());
      end else begin
        e = exp_q.pop_front();
        check_word(tag, e);
      end
    end
  endtask

  task automatic kick(input logic [1:0] m, input logic [HOLD_W-1:0] h, input logic lp);
    @(negedge clk);
    mode        = m;
    hold_cycles = h;
    loop_en     = lp;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; hold_cycles = '0; loop_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_word("reset", 11'd0);
    total++;
    assert (state_dbg === 2'b00) else begin
      bad++;
      $error("FAIL reset_state observed=%b required=00", state_dbg);
    end
    rst = 1'b0;
    @(negedge clk);
    check_word("idle_after_reset", 11'd0);

    // binary, hold 1, no loop
    push_run(2'b00, 1, 16, 1'b1);
    kick(2'b00, 8'd1, 1'b0);
    drain("bin_h1", 18);

    // gray, hold 3; scramble the live inputs mid-run to confirm they are latched
    push_run(2'b01, 3, 16, 1'b1);
    kick(2'b01, 8'd3, 1'b0);
    mode = 2'(2 + $urandom_range(0, 1)); hold_cycles = 8'($urandom_range(5, 200)); loop_en = 1'b1;
    drain("gray_h3", 50);

    // walking-one, hold 0 treated as 1
    push_run(2'b10, 0, 4, 1'b1);
    kick(2'b10, 8'd0, 1'b0);
    drain("walk_h0", 6);

    // walking-one looping: wraps to 1000, no done; stop ends it
    push_run(2'b10, 1, 6, 1'b0);
    kick(2'b10, 8'd1, 1'b1);
    drain("walk_loop", 6);
    stop = 1'b1;
    exp_q.push_back(11'd0);
    drain("walk_loop_stop", 1);
    stop = 1'b0;

    // binary hold 2, start held high through RUN, stop at idx 5, then start+stop in IDLE
    push_run(2'b00, 2, 6, 1'b0);
    kick(2'b00, 8'd2, 1'b0);
    start = 1'b1;
    drain("abort_run", 12);
    stop = 1'b1;
    exp_q.push_back(11'd0);
    exp_q.push_back(11'd0);
    drain("abort_idle", 2);
    stop = 1'b0; start = 1'b0;
    drain_idle_check();

    // reset at idx 9, then restart from 0
    push_run(2'b00, 1, 10, 1'b0);
    kick(2'b00, 8'd1, 1'b0);
    drain("pre_rst", 10);
    rst = 1'b1;
    exp_q.push_back(11'd0);
    drain("mid_rst", 1);
    rst = 1'b0;
    push_run(2'b00, 1, 16, 1'b1);
    kick(2'b00, 8'd1, 1'b0);
    drain("restart", 18);

`ifdef ABCD_STIM_RESP_CHECK_EN
    push_run(2'b00, 2, 16, 1'b1);
    kick(2'b00, 8'd2, 1'b0);
    drain("resp_run", 33);
    total++;
    assert (y1_cnt === 5'd8) else begin
      bad++;
      $error("FAIL y1_cnt observed=%0d required=8", y1_cnt);
    end
    total++;
    assert (y2_cnt === 5'd0) else begin
      bad++;
      $error("FAIL y2_cnt observed=%0d required=0", y2_cnt);
    end
    push_run(2'b00, 2, 1, 1'b0);
    kick(2'b00, 8'd2, 1'b0);
    @(negedge clk);
    total++;
    assert (y1_cnt === 5'd0) else begin
      bad++;
      $error("FAIL y1_clear observed=%0d required=0", y1_cnt);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    exp_q.delete();
`endif

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL leftover observed=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic drain_idle_check();
    @(negedge clk);
    check_word("idle_after_abort", 11'd0);
  endtask

endmodule
